// File: rtl/tcp_tx_flow_sched_pkg.sv
// Shared constants and the TX-pipeline scheduler-update command type
// used by the per-flow transmit scheduler.
package tcp_tx_flow_sched_pkg;

  localparam int SCHED_FLOWS_DEFAULT = 16;
  localparam int MAX_FLOW_CNT        = SCHED_FLOWS_DEFAULT;
  localparam int SCHED_FLOWID_W      = $clog2(SCHED_FLOWS_DEFAULT);

  // Packs into the tx_sched_update_{flowid,set} port pair
  typedef struct packed {
    logic [SCHED_FLOWID_W-1:0] flowid;
    logic                      set;
  } sched_upd_struct;

  localparam int SCHED_UPD_STRUCT_W = SCHED_FLOWID_W + 1;

endpackage

// File: rtl/tcp_tx_flow_sched_if.sv
// Doorbell, TX-pipe update and request handshakes of the flow scheduler.
// The scheduler is the slave; the app/TX pipeline side is the master.
interface tcp_tx_flow_sched_if #(
  parameter int NUM_FLOWS = 16
);
  localparam int FLOWID_W = $clog2(NUM_FLOWS);

  logic                app_sched_val;
  logic [FLOWID_W-1:0] app_sched_flowid;
  logic                app_sched_rdy;

  logic                tx_sched_update_val;
  logic [FLOWID_W-1:0] tx_sched_update_flowid;
  logic                tx_sched_update_set;
  logic                tx_sched_update_rdy;

  logic                sched_tx_req_val;
  logic [FLOWID_W-1:0] sched_tx_req_flowid;
  logic                sched_tx_req_rdy;

  logic [FLOWID_W:0]   pending_cnt;

  modport slave (
    input  app_sched_val, app_sched_flowid,
    output app_sched_rdy,
    input  tx_sched_update_val, tx_sched_update_flowid, tx_sched_update_set,
    output tx_sched_update_rdy,
    output sched_tx_req_val, sched_tx_req_flowid,
    input  sched_tx_req_rdy,
    output pending_cnt
  );

  modport master (
    output app_sched_val, app_sched_flowid,
    input  app_sched_rdy,
    output tx_sched_update_val, tx_sched_update_flowid, tx_sched_update_set,
    input  tx_sched_update_rdy,
    input  sched_tx_req_val, sched_tx_req_flowid,
    output sched_tx_req_rdy,
    input  pending_cnt
  );

endinterface

// File: rtl/tcp_sched_rr_pick.sv
// Round-robin picker: first set bit strictly after ptr, wrapping.
// Rotate so ptr+1 lands at index 0, priority-encode, then un-rotate.
module tcp_sched_rr_pick #(
  parameter int NUM_FLOWS = 16,
  localparam int FLOWID_W = $clog2(NUM_FLOWS)
) (
  input  logic [NUM_FLOWS-1:0] bitmap,
  input  logic [FLOWID_W-1:0]  ptr,
  output logic                 any,
  output logic [FLOWID_W-1:0]  winner
);

  logic [FLOWID_W-1:0]  base;
  logic [NUM_FLOWS-1:0] rot;
  logic [FLOWID_W-1:0]  off;
  logic [FLOWID_W-1:0]  idx;

  assign base = ptr + 1'b1;

  always_comb begin
    rot = '0;
    idx = '0;
    for (int j = 0; j < NUM_FLOWS; j++) begin
      idx    = FLOWID_W'(j) + base;
      rot[j] = bitmap[idx];
    end
  end

  // Scan downward so the lowest set offset is the one that sticks
  always_comb begin
    off = '0;
    for (int j = NUM_FLOWS - 1; j >= 0; j--) begin
      if (rot[j]) off = FLOWID_W'(j);
    end
  end

  assign any    = |bitmap;
  assign winner = off + base;

endmodule

// File: rtl/tcp_tx_flow_sched.sv
// Per-flow TX scheduler: pending bitmap fed by app doorbells and TX-pipe
// commands, drained round-robin into a single registered request slot.
module tcp_tx_flow_sched
  import tcp_tx_flow_sched_pkg::*;
#(
  parameter int NUM_FLOWS = SCHED_FLOWS_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  tcp_tx_flow_sched_if.slave bus
);

  localparam int FLOWID_W = $clog2(NUM_FLOWS);

  function automatic logic [FLOWID_W:0] popcount(input logic [NUM_FLOWS-1:0] v);
    logic [FLOWID_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_FLOWS; i++) c = c + {{FLOWID_W{1'b0}}, v[i]};
    return c;
  endfunction

  logic [NUM_FLOWS-1:0] pend_p0, pend_next;
  logic [FLOWID_W-1:0]  ptr_p0;
  logic                 req_val_p1;
  logic [FLOWID_W-1:0]  req_flowid_p1;
  logic [FLOWID_W:0]    cnt_p1;

  logic                 any;
  logic [FLOWID_W-1:0]  winner;
  logic                 load, held;
  logic [NUM_FLOWS-1:0] grant, set_v, clr_v;

  tcp_sched_rr_pick #(.NUM_FLOWS(NUM_FLOWS)) u_pick (
    .bitmap (pend_p0),
    .ptr    (ptr_p0),
    .any    (any),
    .winner (winner)
  );

  assign load  = !req_val_p1 || bus.sched_tx_req_rdy;
  assign held  = req_val_p1 && !bus.sched_tx_req_rdy;
  assign grant = (load && any) ? (NUM_FLOWS'(1) << winner) : '0;

  // A set for the flow parked in the output slot is absorbed: that request
  // will still be served, so marking it again would cause a duplicate grant.
  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int i = 0; i < NUM_FLOWS; i++) begin
      set_v[i] = ((bus.app_sched_val && bus.app_sched_flowid == FLOWID_W'(i)) ||
                  (bus.tx_sched_update_val && bus.tx_sched_update_set &&
                   bus.tx_sched_update_flowid == FLOWID_W'(i))) &&
                 !(held && req_flowid_p1 == FLOWID_W'(i));
      clr_v[i] = bus.tx_sched_update_val && !bus.tx_sched_update_set &&
                 bus.tx_sched_update_flowid == FLOWID_W'(i);
    end
    pend_next = (pend_p0 & ~grant & ~clr_v) | set_v;
  end

  // ---- stage p0: pending bitmap and round-robin pointer ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_p0 <= '0;
      ptr_p0  <= FLOWID_W'(NUM_FLOWS - 1);
    end else begin
      pend_p0 <= pend_next;
      if (load && any) ptr_p0 <= winner;
    end
  end

  // ---- stage p1: request output slot and population count ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_val_p1    <= 1'b0;
      req_flowid_p1 <= '0;
      cnt_p1        <= '0;
    end else begin
      cnt_p1 <= popcount(pend_next);
      if (load) begin
        req_val_p1 <= any;
        if (any) req_flowid_p1 <= winner;
      end
    end
  end

  assign bus.app_sched_rdy       = !rst;
  assign bus.tx_sched_update_rdy = !rst;
  assign bus.sched_tx_req_val    = req_val_p1;
  assign bus.sched_tx_req_flowid = req_flowid_p1;
  assign bus.pending_cnt         = cnt_p1;

endmodule
